usb_ep_ctrl: RTL and testbench

USB_EP_CTRL -- requirements
Module: usb_ep_ctrl

---
 rtl/usb_ep_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_usb_ep_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_ctrl.sv
// ---------------------------------------------------------------------------
// usb_ep_ctrl -- USB device endpoint transaction controller.
//
// Sequences OUT/SETUP/IN transactions for NEP endpoints: latches the token,
// decides the handshake (ACK/NAK/STALL) from registered FIFO status, tracks
// per-endpoint DATA0/DATA1 toggles and launches IN data packets, waiting up
// to TIMEOUT clocks for the host ACK.
//
// Parameters:
//   NEP      number of endpoints (1..16)
//   TIMEOUT  clk cycles to wait for a host ACK after IN data
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   usb_reset               synchronous USB bus reset
//   tok_valid/pid/endp      decoded token pulse
//   data_valid/data_pid     PID of the received DATA packet
//   data_done/data_crc_ok   end of OUT/SETUP data with CRC16 result
//   in_empty, out_full      per-endpoint FIFO status
//   stall_set, stall_clr    firmware stall control pulses
//   hs_valid/hs_pid/ready   handshake request to the SIE
//   in_start/in_pid/done    IN data launch and completion
//   ep_sel, out_discard     selected endpoint, duplicate-OUT pulse
//   tog_in, tog_out, stalled per-endpoint toggle and stall bits
//
// Build option: define USB_EP_STALL_EN to implement stall registers and
// STALL handshakes; otherwise stalled reads 0 and stall inputs are ignored.
// ---------------------------------------------------------------------------
module usb_ep_ctrl #(
    parameter int unsigned NEP     = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           usb_reset,
    input  logic           tok_valid,
    input  logic [3:0]     tok_pid,
    input  logic [3:0]     tok_endp,
    input  logic           data_valid,
    input  logic [3:0]     data_pid,
    input  logic           data_done,
    input  logic           data_crc_ok,
    input  logic [NEP-1:0] in_empty,
    input  logic [NEP-1:0] out_full,
    input  logic [NEP-1:0] stall_set,
    input  logic [NEP-1:0] stall_clr,
    output logic           hs_valid,
    output logic [3:0]     hs_pid,
    input  logic           hs_ready,
    output logic           in_start,
    output logic [3:0]     in_pid,
    input  logic           in_done,
    output logic [3:0]     ep_sel,
    output logic           out_discard,
    output logic [NEP-1:0] tog_in,
    output logic [NEP-1:0] tog_out,
    output logic [NEP-1:0] stalled
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, OUT_DATA, OUT_HS, IN_DATA, IN_WAIT, IN_HS
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_setup;
    logic [3:0]    data_pid_q;

    // Per-endpoint state is held 16 wide so the 4-bit ep_sel/tok_endp can
    // index it directly; bits at or above NEP are never written.
    logic [15:0]   tog_in_q, tog_out_q, stalled_q;
    logic [15:0]   in_empty_w, out_full_w, in_empty_r, out_full_r;

    logic          tok_ok;
    logic [3:0]    pid_eff;

    always_comb begin
        in_empty_w          = '0;
        out_full_w          = '0;
        in_empty_w[NEP-1:0] = in_empty;
        out_full_w[NEP-1:0] = out_full;
    end

    always_comb begin
        tok_ok  = ({28'd0, tok_endp} < NEP) &&
                  (tok_pid == PID_OUT || tok_pid == PID_IN || tok_pid == PID_SETUP);
        // DATA PID may arrive in the same cycle as data_done
        pid_eff = data_valid ? data_pid : data_pid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_empty_r <= '0;
            out_full_r <= '0;
        end else begin
            in_empty_r <= in_empty_w;
            out_full_r <= out_full_w;
        end
    end

`ifndef USB_EP_STALL_EN
    logic unused_stall;
    assign unused_stall = ^{stall_set, stall_clr};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hs_valid    <= 1'b0;
            hs_pid      <= '0;
            in_start    <= 1'b0;
            in_pid      <= '0;
            ep_sel      <= '0;
            out_discard <= 1'b0;
            tog_in_q    <= '0;
            tog_out_q   <= '0;
            stalled_q   <= '0;
            cnt         <= '0;
            is_setup    <= 1'b0;
            data_pid_q  <= '0;
        end else begin
            in_start    <= 1'b0;
            out_discard <= 1'b0;
`ifdef USB_EP_STALL_EN
            // Set beats clear; a SETUP clear of ep0 below overrides both.
            for (int unsigned i = 0; i < NEP; i++) begin
                if (stall_set[i])
                    stalled_q[i] <= 1'b1;
                else if (stall_clr[i])
                    stalled_q[i] <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (tok_valid && tok_ok) begin
                        ep_sel     <= tok_endp;
                        is_setup   <= (tok_pid == PID_SETUP);
                        data_pid_q <= '0;
                        if (tok_pid == PID_IN) begin
                            if (stalled_q[tok_endp] || in_empty_r[tok_endp]) begin
                                state    <= IN_HS;
                                hs_valid <= 1'b1;
                                hs_pid   <= stalled_q[tok_endp] ? PID_STALL : PID_NAK;
                            end else begin
                                state    <= IN_DATA;
                                in_start <= 1'b1;
                                in_pid   <= tog_in_q[tok_endp] ? PID_DATA1 : PID_DATA0;
                            end
                        end else begin
                            state <= OUT_DATA;
                        end
                    end
                end
                OUT_DATA: begin
                    if (tok_valid) begin
                        state <= IDLE;
                    end else begin
                        if (data_valid)
                            data_pid_q <= data_pid;
                        if (data_done) begin
                            if (!data_crc_ok) begin
                                state <= IDLE;
                            end else if (is_setup) begin
                                if (pid_eff == PID_DATA0) begin
                                    state        <= OUT_HS;
                                    hs_valid     <= 1'b1;
                                    hs_pid       <= PID_ACK;
                                    stalled_q[0] <= 1'b0;
                                    tog_out_q[0] <= 1'b1;
                                    tog_in_q[0]  <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                state    <= OUT_HS;
                                hs_valid <= 1'b1;
                                if (stalled_q[ep_sel]) begin
                                    hs_pid <= PID_STALL;
                                end else if (out_full_r[ep_sel]) begin
                                    hs_pid <= PID_NAK;
                                end else if (pid_eff[3] == tog_out_q[ep_sel]) begin
                                    hs_pid            <= PID_ACK;
                                    tog_out_q[ep_sel] <= ~tog_out_q[ep_sel];
                                end else begin
                                    hs_pid      <= PID_ACK;
                                    out_discard <= 1'b1;
                                end
                            end
                        end
                    end
                end
                OUT_HS, IN_HS: begin
                    if (hs_ready) begin
                        hs_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                IN_DATA: begin
                    if (in_done) begin
                        state <= IN_WAIT;
                        cnt   <= CW'(TIMEOUT - 1);
                    end
                end
                IN_WAIT: begin
                    if (tok_valid) begin
                        state <= IDLE;
                        if (tok_pid == PID_ACK)
                            tog_in_q[ep_sel] <= ~tog_in_q[ep_sel];
                    end else if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (usb_reset) begin
                state       <= IDLE;
                hs_valid    <= 1'b0;
                in_start    <= 1'b0;
                out_discard <= 1'b0;
                tog_in_q    <= '0;
                tog_out_q   <= '0;
                stalled_q   <= '0;
            end
        end
    end

    assign tog_in  = tog_in_q[NEP-1:0];
    assign tog_out = tog_out_q[NEP-1:0];
    assign stalled = stalled_q[NEP-1:0];

endmodule

// File: tb/tb_usb_ep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_ctrl -- self-checking bench for usb_ep_ctrl.
// Directed scenarios plus randomized transactions, compared against a
// transaction-level model of toggle/stall/handshake rules.
// ---------------------------------------------------------------------------
module tb_usb_ep_ctrl;

    localparam int unsigned NEP     = 4;
    localparam int unsigned TIMEOUT = 40;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_SETUP = 4'b1101;
    localparam logic [3:0] P_SOF   = 4'b0101;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_DATA1 = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [3:0] P_STALL = 4'b1110;

`ifdef USB_EP_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           usb_reset = 1'b0;
    logic           tok_valid = 1'b0;
    logic [3:0]     tok_pid = '0;
    logic [3:0]     tok_endp = '0;
    logic           data_valid = 1'b0;
    logic [3:0]     data_pid = '0;
    logic           data_done = 1'b0;
    logic           data_crc_ok = 1'b0;
    logic [NEP-1:0] in_empty = '0;
    logic [NEP-1:0] out_full = '0;
    logic [NEP-1:0] stall_set = '0;
    logic [NEP-1:0] stall_clr = '0;
    logic           hs_ready = 1'b0;
    logic           in_done = 1'b0;
    logic           hs_valid;
    logic [3:0]     hs_pid;
    logic           in_start;
    logic [3:0]     in_pid;
    logic [3:0]     ep_sel;
    logic           out_discard;
    logic [NEP-1:0] tog_in, tog_out, stalled;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of the per-endpoint bits
    logic [NEP-1:0] m_tog_in, m_tog_out, m_stalled;

    usb_ep_ctrl #(.NEP(NEP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .usb_reset(usb_reset),
        .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_endp(tok_endp),
        .data_valid(data_valid), .data_pid(data_pid),
        .data_done(data_done), .data_crc_ok(data_crc_ok),
        .in_empty(in_empty), .out_full(out_full),
        .stall_set(stall_set), .stall_clr(stall_clr),
        .hs_valid(hs_valid), .hs_pid(hs_pid), .hs_ready(hs_ready),
        .in_start(in_start), .in_pid(in_pid), .in_done(in_done),
        .ep_sel(ep_sel), .out_discard(out_discard),
        .tog_in(tog_in), .tog_out(tog_out), .stalled(stalled)
    );

    always #21 clk = ~clk;

    initial begin
        #2500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input logic [3:0] pid, input int unsigned ep);
        tok_valid = 1'b1;
        tok_pid   = pid;
        tok_endp  = 4'(ep);
        tick();
        tok_valid = 1'b0;
        tok_pid   = '0;
        tok_endp  = '0;
    endtask

    task automatic set_status(input logic [NEP-1:0] ie, input logic [NEP-1:0] of);
        in_empty = ie;
        out_full = of;
        tick();
    endtask

    // OUT or SETUP transaction; hold=1 leaves the handshake pending.
    task automatic do_out(input logic [3:0] tpid, input int unsigned ep,
                          input logic [3:0] dpid, input bit crc,
                          input bit hold, input bit stall0_same);
        bit         ev, edisc, setup_clr;
        logic [3:0] epid;
        ev = 1'b0; edisc = 1'b0; setup_clr = 1'b0; epid = P_ACK;
        if (crc) begin
            if (tpid == P_SETUP) begin
                if (dpid == P_DATA0) begin
                    ev = 1'b1; setup_clr = 1'b1;
                    m_tog_out[0] = 1'b1;
                    m_tog_in[0]  = 1'b1;
                end
            end else if (m_stalled[ep]) begin
                ev = 1'b1; epid = P_STALL;
            end else if (out_full[ep]) begin
                ev = 1'b1; epid = P_NAK;
            end else if ((dpid == P_DATA1) == m_tog_out[ep]) begin
                ev = 1'b1;
                m_tog_out[ep] = ~m_tog_out[ep];
            end else begin
                ev = 1'b1; edisc = 1'b1;
            end
        end
        if (STALL_EN && stall0_same) m_stalled[0] = 1'b1;
        if (setup_clr) m_stalled[0] = 1'b0;

        send_tok(tpid, ep);
        data_valid = 1'b1; data_pid = dpid;
        tick();
        data_valid = 1'b0; data_pid = '0;
        data_done = 1'b1; data_crc_ok = crc;
        if (stall0_same) stall_set[0] = 1'b1;
        tick();
        data_done = 1'b0; data_crc_ok = 1'b0; stall_set = '0;

        checks++;
        if (hs_valid !== ev) begin
            failures++;
            $display("FAIL out_hs_valid ep%0d: got %b want %b", ep, hs_valid, ev);
        end
        checks++;
        if (ev && hs_pid !== epid) begin
            failures++;
            $display("FAIL out_hs_pid ep%0d: got %h want %h", ep, hs_pid, epid);
        end
        checks++;
        if (out_discard !== edisc) begin
            failures++;
            $display("FAIL out_discard ep%0d: got %b want %b", ep, out_discard, edisc);
        end
        checks++;
        if (ep_sel !== 4'(ep)) begin
            failures++;
            $display("FAIL out_ep_sel: got %0d want %0d", ep_sel, ep);
        end
        checks++;
        if ({tog_in, tog_out, stalled} !== {m_tog_in, m_tog_out, m_stalled}) begin
            failures++;
            $display("FAIL out_bits: got in=%b out=%b st=%b want in=%b out=%b st=%b",
                     tog_in, tog_out, stalled, m_tog_in, m_tog_out, m_stalled);
        end
        if (ev) begin
            if (!hold) begin
                tick();
                checks++;
                if (hs_valid !== 1'b1 || hs_pid !== epid || out_discard !== 1'b0) begin
                    failures++;
                    $display("FAIL out_hs_hold: got v=%b pid=%h disc=%b want v=1 pid=%h disc=0",
                             hs_valid, hs_pid, out_discard, epid);
                end
                hs_ready = 1'b1;
                tick();
                hs_ready = 1'b0;
                checks++;
                if (hs_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL out_hs_release: got %b want 0", hs_valid);
                end
            end
        end else begin
            tick();
            checks++;
            if (hs_valid !== 1'b0) begin
                failures++;
                $display("FAIL out_no_hs: got %b want 0", hs_valid);
            end
        end
    endtask

    // IN transaction. mode 0: ACK after 'delay' idle cycles; mode 1: SOF
    // then ACK after 'delay' cycles (neither may flip the toggle).
    task automatic do_in(input int unsigned ep, input int unsigned mode,
                         input int unsigned delay);
        bit         ehs;
        logic [3:0] epid, dpid;
        ehs  = m_stalled[ep] || in_empty[ep];
        epid = m_stalled[ep] ? P_STALL : P_NAK;
        dpid = m_tog_in[ep] ? P_DATA1 : P_DATA0;
        send_tok(P_IN, ep);
        if (ehs) begin
            checks++;
            if (hs_valid !== 1'b1 || in_start !== 1'b0 || hs_pid !== epid) begin
                failures++;
                $display("FAIL in_hs ep%0d: got v=%b start=%b pid=%h want v=1 start=0 pid=%h",
                         ep, hs_valid, in_start, hs_pid, epid);
            end
            tick();
            checks++;
            if (hs_valid !== 1'b1 || hs_pid !== epid) begin
                failures++;
                $display("FAIL in_hs_hold ep%0d: got v=%b pid=%h want v=1 pid=%h",
                         ep, hs_valid, hs_pid, epid);
            end
            hs_ready = 1'b1;
            tick();
            hs_ready = 1'b0;
            checks++;
            if (hs_valid !== 1'b0) begin
                failures++;
                $display("FAIL in_hs_release: got %b want 0", hs_valid);
            end
        end else begin
            checks++;
            if (in_start !== 1'b1 || hs_valid !== 1'b0 || in_pid !== dpid) begin
                failures++;
                $display("FAIL in_start ep%0d: got start=%b hs=%b pid=%h want start=1 hs=0 pid=%h",
                         ep, in_start, hs_valid, in_pid, dpid);
            end
            tick();
            checks++;
            if (in_start !== 1'b0) begin
                failures++;
                $display("FAIL in_start_pulse: got %b want 0", in_start);
            end
            tick();
            in_done = 1'b1;
            tick();
            in_done = 1'b0;
            if (mode == 1) send_tok(P_SOF, 0);
            repeat (delay) tick();
            send_tok(P_ACK, 0);
            if (mode == 0 && delay < TIMEOUT) m_tog_in[ep] = ~m_tog_in[ep];
            checks++;
            if (tog_in !== m_tog_in || in_start !== 1'b0 || hs_valid !== 1'b0) begin
                failures++;
                $display("FAIL in_ack ep%0d d=%0d m=%0d: got tog_in=%b start=%b hs=%b want tog_in=%b start=0 hs=0",
                         ep, delay, mode, tog_in, in_start, hs_valid, m_tog_in);
            end
        end
    endtask

    task automatic do_stall(input logic [NEP-1:0] s, input logic [NEP-1:0] c);
        stall_set = s;
        stall_clr = c;
        tick();
        stall_set = '0;
        stall_clr = '0;
        if (STALL_EN) m_stalled = s | (m_stalled & ~c);
        checks++;
        if (stalled !== m_stalled) begin
            failures++;
            $display("FAIL stall_ctl set=%b clr=%b: got %b want %b", s, c, stalled, m_stalled);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({hs_valid, hs_pid, in_start, in_pid, ep_sel, out_discard} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0",
                     {hs_valid, hs_pid, in_start, in_pid, ep_sel, out_discard});
        end
        checks++;
        if ({tog_in, tog_out, stalled} !== '0) begin
            failures++;
            $display("FAIL reset_bits: got %b want 0", {tog_in, tog_out, stalled});
        end
        reset_n = 1'b1;
        tick();
        m_tog_in = '0; m_tog_out = '0; m_stalled = '0;
        checks++;
        if (hs_valid !== 1'b0 || in_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got hs=%b start=%b want 0 0", hs_valid, in_start);
        end
    endtask

    task automatic test_out_toggle();
        set_status('0, '0);
        do_out(P_OUT, 1, P_DATA0, 1'b1, 1'b0, 1'b0);   // ACK, tog_out[1] -> 1
        checks++;
        if (tog_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL out_tog1: got %b want 1", tog_out[1]);
        end
        do_out(P_OUT, 1, P_DATA0, 1'b1, 1'b0, 1'b0);   // duplicate: discard
        do_out(P_OUT, 1, P_DATA1, 1'b1, 1'b0, 1'b0);   // ACK, flip back
        set_status('0, 4'b0010);
        do_out(P_OUT, 1, P_DATA0, 1'b1, 1'b0, 1'b0);   // NAK
    endtask

    task automatic test_in_timeout();
        set_status('0, '0);
        do_in(2, 0, 5);                 // ACK: tog_in[2] -> 1
        do_in(2, 0, TIMEOUT);           // DATA1, ACK one cycle too late
        checks++;
        if (tog_in[2] !== 1'b1) begin
            failures++;
            $display("FAIL in_timeout_tog: got %b want 1", tog_in[2]);
        end
        do_in(2, 0, TIMEOUT - 1);       // last cycle still accepts the ACK
        do_in(2, 1, 0);                 // other token ends the wait
    endtask

    task automatic test_stall_setup();
        set_status('1, '0);
        do_stall(4'b1000, '0);
        do_in(3, 0, 0);                                 // STALL (NAK if stall off)
        do_out(P_OUT, 3, P_DATA0, 1'b1, 1'b0, 1'b0);
        do_stall(4'b0001, '0);
        do_out(P_SETUP, 0, P_DATA0, 1'b1, 1'b0, 1'b0);  // ACK, unstall ep0
        do_out(P_SETUP, 0, P_DATA0, 1'b1, 1'b0, 1'b1);  // clear beats same-cycle set
        do_out(P_SETUP, 0, P_DATA1, 1'b1, 1'b0, 1'b0);  // not DATA0: silent
        do_stall(4'b0100, 4'b0100);                     // set wins
        do_stall('0, 4'b1100);
    endtask

    task automatic test_crc_nak();
        set_status(4'b0001, '0);
        do_out(P_OUT, 0, P_DATA0, 1'b0, 1'b0, 1'b0);    // bad CRC: no handshake
        do_in(0, 0, 0);                                 // empty: NAK
    endtask

    task automatic test_ignored_tokens();
        set_status('1, '0);
        do_in(1, 0, 0);
        send_tok(P_OUT, NEP);
        send_tok(P_SOF, 2);
        data_done = 1'b1; data_crc_ok = 1'b1;
        tick();
        data_done = 1'b0; data_crc_ok = 1'b0;
        tick();
        checks++;
        if (hs_valid !== 1'b0 || ep_sel !== 4'd1) begin
            failures++;
            $display("FAIL ignored_tok: got hs=%b ep=%0d want hs=0 ep=1", hs_valid, ep_sel);
        end
        set_status('0, '0);
        send_tok(P_OUT, 1);
        send_tok(P_IN, 2);                              // aborts, itself ignored
        checks++;
        if (in_start !== 1'b0 || hs_valid !== 1'b0 || ep_sel !== 4'd1) begin
            failures++;
            $display("FAIL abort_tok: got start=%b hs=%b ep=%0d want 0 0 1",
                     in_start, hs_valid, ep_sel);
        end
        data_valid = 1'b1; data_pid = P_DATA0; data_done = 1'b1; data_crc_ok = 1'b1;
        tick();
        data_valid = 1'b0; data_pid = '0; data_done = 1'b0; data_crc_ok = 1'b0;
        tick();
        checks++;
        if (hs_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_data: got hs=%b want 0", hs_valid);
        end
    endtask

    task automatic test_reset_midflight();
        set_status('0, '0);
        do_out(P_OUT, 1, (m_tog_out[1] ? P_DATA1 : P_DATA0), 1'b1, 1'b0, 1'b0);
        send_tok(P_IN, 2);
        tick();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        #5 reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_valid, hs_pid, in_start, in_pid, ep_sel, out_discard,
             tog_in, tog_out, stalled} !== '0) begin
            failures++;
            $display("FAIL async_reset: got hs=%b pid=%h st=%b ip=%h ep=%0d d=%b ti=%b to=%b sl=%b",
                     hs_valid, hs_pid, in_start, in_pid, ep_sel, out_discard,
                     tog_in, tog_out, stalled);
        end
        tick();
        reset_n = 1'b1;
        m_tog_in = '0; m_tog_out = '0; m_stalled = '0;
        tick();
        do_in(2, 0, 2);                                 // DATA0, IDLE after reset
        do_stall(4'b1000, '0);
        do_out(P_OUT, 1, P_DATA0, 1'b1, 1'b0, 1'b0);
        do_out(P_OUT, 2, P_DATA0, 1'b1, 1'b1, 1'b0);    // left in OUT_HS
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        m_tog_in = '0; m_tog_out = '0; m_stalled = '0;
        checks++;
        if (hs_valid !== 1'b0 || out_discard !== 1'b0 ||
            {tog_in, tog_out, stalled} !== '0) begin
            failures++;
            $display("FAIL usb_reset: got hs=%b d=%b ti=%b to=%b sl=%b want all 0",
                     hs_valid, out_discard, tog_in, tog_out, stalled);
        end
        do_in(1, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int unsigned kind, ep, sel, dly;
            set_status(NEP'($urandom), NEP'($urandom & $urandom));
            kind = $urandom_range(0, 4);
            ep   = $urandom_range(0, NEP - 1);
            if (kind <= 1) begin
                do_out(P_OUT, ep, ($urandom_range(0, 1) != 0) ? P_DATA1 : P_DATA0,
                       $urandom_range(0, 4) != 0, 1'b0, 1'b0);
            end else if (kind == 2) begin
                do_out(P_SETUP, 0, ($urandom_range(0, 3) != 0) ? P_DATA0 : P_DATA1,
                       $urandom_range(0, 4) != 0, 1'b0, $urandom_range(0, 1) != 0);
            end else if (kind == 3) begin
                sel = $urandom_range(0, 3);
                if (sel == 0)      dly = $urandom_range(0, 5);
                else if (sel == 1) dly = TIMEOUT - 1;
                else if (sel == 2) dly = TIMEOUT;
                else               dly = $urandom_range(0, TIMEOUT + 2);
                do_in(ep, $urandom_range(0, 3) == 0 ? 1 : 0, dly);
            end else begin
                do_stall(NEP'($urandom & $urandom), NEP'($urandom));
            end
        end
    endtask

    initial begin
        m_tog_in = '0; m_tog_out = '0; m_stalled = '0;
        test_reset();
        test_out_toggle();
        test_in_timeout();
        test_stall_setup();
        test_crc_nak();
        test_ignored_tokens();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
